// File: rtl/ram8_stream_reader_pkg.sv
// Shared types and RAM8 geometry for the RAM8 stream reader.
package ram8_stream_reader_pkg;

  localparam int K     = 3;
  localparam int DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ram8_stream_reader.sv
// Walks a wrapping address window of a RAM8 array and streams each word out on valid/ready.
// Optional running sum of accepted words when RAM8_STREAM_READER_SUM_EN is defined.
//
// state     | meaning
// ST_IDLE   | waiting for start; base/count sampled here
// ST_STREAM | fetching words and holding them under backpressure
// ST_DONE   | one-cycle completion pulse
module ram8_stream_reader
  import ram8_stream_reader_pkg::*;
#(
  parameter int width = 16,
  parameter int k     = K
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [k-1:0]     base,
  input  logic [k:0]       count,
  output logic [k-1:0]     ram_address,
  output logic             ram_load,
  input  logic [width-1:0] ram_data,
  output logic [width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
`ifdef RAM8_STREAM_READER_SUM_EN
  ,
  output logic [width-1:0] sum
`endif
);

  state_t           state_q, state_d;
  logic [k-1:0]     addr_q, addr_d;
  logic [k:0]       remaining_q, remaining_d;
  logic [width-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             fetch;
  logic             slot_free;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // The output slot can take a new word if it is empty or being drained this cycle.
  assign slot_free = !out_valid_q || out_ready;
  assign fetch     = (state_q == ST_STREAM) && (remaining_q != '0) && slot_free;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d      = base;
          remaining_d = count;
          state_d     = (count != '0) ? ST_STREAM : ST_DONE;
        end
      end
      ST_STREAM: begin
        if (fetch) begin
          out_data_d  = ram_data;
          out_valid_d = 1'b1;
          addr_d      = addr_q + k'(1);
          remaining_d = remaining_q - (k+1)'(1);
        end else if (remaining_q == '0 && slot_free) begin
          out_valid_d = 1'b0;
          state_d     = ST_DONE;
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ram_address = addr_q;
  assign ram_load    = 1'b0;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign busy        = (state_q == ST_STREAM);
  assign done        = (state_q == ST_DONE);

`ifdef RAM8_STREAM_READER_SUM_EN
  logic [width-1:0] sum_q, sum_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  always_comb begin
    sum_d = sum_q;
    if (state_q == ST_IDLE && start) sum_d = '0;
    else if (out_valid_q && out_ready) sum_d = sum_q + out_data_q;
  end

  assign sum = sum_q;
`endif

endmodule

// File: tb/tb_ram8_stream_reader.sv
// Self-checking bench for ram8_stream_reader with an array RAM8 model and a queue-based reference.
module tb_ram8_stream_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  base;
  logic [3:0]  count;
  logic [2:0]  ram_address;
  logic        ram_load;
  logic [15:0] ram_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
`ifdef RAM8_STREAM_READER_SUM_EN
  logic [15:0] sum;
`endif

  logic [15:0] mem [8];
  assign ram_data = mem[ram_address];

  always #5 clk = ~clk;

  ram8_stream_reader #(.width(16), .k(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base       (base),
    .count      (count),
    .ram_address(ram_address),
    .ram_load   (ram_load),
    .ram_data   (ram_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
`ifdef RAM8_STREAM_READER_SUM_EN
    ,
    .sum        (sum)
`endif
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_q [$];
  logic [15:0] sum_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 8; i++) mem[i] = 16'h1000 + 16'(i);
  endtask

  // mode 0: ready always high; 1: random ready and stray starts; 2: three stall cycles on first word
  task automatic run_scan(input int b, input int c, input int mode);
    int   xfers;
    int   stalls;
    int   first_valid;
    int   done_cyc;
    logic rdy;
    exp_q.delete();
    for (int i = 0; i < c; i++) exp_q.push_back(mem[(b + i) % 8]);
    sum_m       = '0;
    xfers       = 0;
    stalls      = 0;
    first_valid = -1;
    done_cyc    = -1;
    @(negedge clk);
    start     = 1'b1;
    base      = 3'(b);
    count     = 4'(c);
    out_ready = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      start = 1'b0;
`ifdef RAM8_STREAM_READER_SUM_EN
      if (cyc == 1) check("sum_cleared", 32'(sum), 0);
`endif
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (mode == 1 && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        base  = 3'($urandom_range(0, 7));
        count = 4'($urandom_range(0, 8));
      end
      check("busy_in_scan", 32'(busy), 1);
      check("ram_address", 32'(ram_address), 32'((b + xfers + (out_valid ? 1 : 0)) % 8));
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (exp_q.size() == 0) check("extra_word", 1, 0);
        else check("out_data", 32'(out_data), 32'(exp_q[0]));
      end
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = 1'($urandom_range(0, 1));
      else if (out_valid && stalls < 3) begin
        rdy = 1'b0;
        stalls++;
        mem[(b + xfers) % 8] = mem[(b + xfers) % 8] ^ 16'hFFFF;
      end else rdy = 1'b1;
      out_ready = rdy;
      if (out_valid && rdy && exp_q.size() != 0) begin
        sum_m = sum_m + exp_q.pop_front();
        xfers++;
      end
    end
    start     = 1'b0;
    out_ready = 1'b1;
    if (done_cyc < 0) check("timeout", 0, 1);
    check("transfers", 32'(xfers), 32'(c));
    check("busy_at_done", 32'(busy), 0);
    check("valid_at_done", 32'(out_valid), 0);
    if (mode == 0) begin
      check("done_cycle", 32'(done_cyc), 32'((c == 0) ? 1 : c + 2));
      if (c > 0) check("first_valid_cycle", 32'(first_valid), 2);
    end
    if (mode == 2) check("stall_cycles", 32'(stalls), 3);
`ifdef RAM8_STREAM_READER_SUM_EN
    check("sum_at_done", 32'(sum), 32'(sum_m));
`endif
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
    check("busy_idle", 32'(busy), 0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    base      = '0;
    count     = '0;
    out_ready = 1'b1;
    preload();
    #12;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_address", 32'(ram_address), 0);
    check("rst_data", 32'(out_data), 0);
    check("ram_load", 32'(ram_load), 0);
    @(negedge clk);
    reset = 1'b0;

    run_scan(0, 8, 0);
`ifdef RAM8_STREAM_READER_SUM_EN
    check("sum_full_scan", 32'(sum), 32'h801C);
    @(negedge clk);
    check("sum_holds_idle", 32'(sum), 32'h801C);
`endif
    run_scan(6, 4, 0);
    run_scan(2, 3, 2);
    preload();
    run_scan(0, 0, 0);
    run_scan(7, 1, 0);

    repeat (12) begin
      for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
      run_scan($urandom_range(0, 7), $urandom_range(0, 8), 1);
    end

    preload();
    @(negedge clk);
    start = 1'b1; base = 3'd0; count = 4'd8;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_abort_valid", 32'(out_valid), 1);
    check("pre_abort_data", 32'(out_data), 32'h1000);
    start = 1'b1; base = 3'd5; count = 4'd2;
    @(negedge clk);
    start = 1'b0;
    check("ignored_start_addr", 32'(ram_address), 2);
    check("ignored_start_data", 32'(out_data), 32'h1001);
    #2 reset = 1'b1;
    #1;
    check("abort_valid", 32'(out_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_address", 32'(ram_address), 0);
    check("abort_data", 32'(out_data), 0);
    @(negedge clk);
    reset = 1'b0;
    run_scan(3, 5, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
